// File: rtl/taxi_eth_mac_addr_swap.sv
// Swaps Ethernet destination and source MAC addresses on a 64-bit AXI stream.
// Beat 0 is parked in a hold register, and each frame flows through a two-entry output buffer.
module taxi_eth_mac_addr_swap #(
    parameter int DATA_W = 64,
    parameter int KEEP_W = 8,
    parameter int ID_W   = 8,
    parameter int USER_W = 1
) (
    input  logic              clk,
    input  logic              rst,

    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic [KEEP_W-1:0] s_axis_tkeep,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic              s_axis_tlast,
    input  logic [ID_W-1:0]   s_axis_tid,
    input  logic [USER_W-1:0] s_axis_tuser,

    output logic [DATA_W-1:0] m_axis_tdata,
    output logic [KEEP_W-1:0] m_axis_tkeep,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast,
    output logic [ID_W-1:0]   m_axis_tid,
    output logic [USER_W-1:0] m_axis_tuser,

    input  logic              cfg_enable,
    output logic [31:0]       stat_swap_cnt,
    output logic [15:0]       stat_runt_cnt
);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [KEEP_W-1:0] keep;
        logic              last;
        logic [ID_W-1:0]   id;
        logic [USER_W-1:0] user;
        logic              inc_swap;
        logic              inc_runt;
    } beat_t;

    typedef enum logic [1:0] {StIdle, StHold, StBody} state_e;

    state_e      state_q, state_d;
    beat_t       hold_q, hold_d;
    logic        swap_q, swap_d;
    beat_t       ent0_q, ent0_d, ent1_q, ent1_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] swap_cnt_q, swap_cnt_d;
    logic [15:0] runt_cnt_q, runt_cnt_d;

    beat_t       in_beat, swp0, swp1, push_a, push_b;
    logic        push_a_en, push_b_en;
    logic        s_fire, m_fire, beat1_runt;
    logic [1:0]  free;

    assign m_axis_tvalid = (cnt_q != 2'd0) && !rst;
    assign m_fire        = m_axis_tvalid && m_axis_tready;
    assign s_fire        = s_axis_tvalid && s_axis_tready;
    // Buffer slots available at the coming edge, counting the beat being drained now.
    assign free          = 2'd2 - cnt_q + {1'b0, m_fire};
    assign beat1_runt    = s_axis_tlast && (s_axis_tkeep[3:0] != 4'hF);

    assign m_axis_tdata  = ent0_q.data;
    assign m_axis_tkeep  = ent0_q.keep;
    assign m_axis_tlast  = ent0_q.last;
    assign m_axis_tid    = ent0_q.id;
    assign m_axis_tuser  = ent0_q.user;
    assign stat_swap_cnt = swap_cnt_q;
    assign stat_runt_cnt = runt_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (s_fire && !s_axis_tlast) state_d = StHold;
            StHold:  if (s_fire) state_d = s_axis_tlast ? StIdle : StBody;
            StBody:  if (s_fire && s_axis_tlast) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // The HOLD stage emits two beats at once, so it needs both buffer slots.
    always_comb begin
        s_axis_tready = 1'b0;
        if (!rst) begin
            case (state_q)
                StHold:  s_axis_tready = (free == 2'd2);
                default: s_axis_tready = (free != 2'd0);
            endcase
        end
    end

    always_comb begin
        in_beat      = '0;
        in_beat.data = s_axis_tdata;
        in_beat.keep = s_axis_tkeep;
        in_beat.last = s_axis_tlast;
        in_beat.id   = s_axis_tid;
        in_beat.user = s_axis_tuser;

        swp0      = hold_q;
        swp0.data = {hold_q.data[15:0], s_axis_tdata[31:0], hold_q.data[63:48]};
        swp1      = in_beat;
        swp1.data = {s_axis_tdata[63:32], hold_q.data[47:16]};

        hold_d    = hold_q;
        swap_d    = swap_q;
        push_a_en = 1'b0;
        push_b_en = 1'b0;
        push_a    = '0;
        push_b    = '0;

        if (s_fire) begin
            case (state_q)
                StIdle: begin
                    if (s_axis_tlast) begin
                        push_a_en        = 1'b1;
                        push_a           = in_beat;
                        push_a.inc_runt  = cfg_enable;
                    end else begin
                        hold_d = in_beat;
                        swap_d = cfg_enable;
                    end
                end
                StHold: begin
                    push_a_en = 1'b1;
                    push_b_en = 1'b1;
                    if (swap_q && !beat1_runt) begin
                        push_a          = swp0;
                        push_b          = swp1;
                        push_b.inc_swap = 1'b1;
                    end else begin
                        push_a          = hold_q;
                        push_b          = in_beat;
                        push_b.inc_runt = swap_q && beat1_runt;
                    end
                end
                default: begin
                    push_a_en = 1'b1;
                    push_a    = in_beat;
                end
            endcase
        end
    end

    always_comb begin
        ent0_d = ent0_q;
        ent1_d = ent1_q;
        cnt_d  = cnt_q;
        if (m_fire) begin
            ent0_d = ent1_q;
            cnt_d  = cnt_q - 2'd1;
        end
        if (push_a_en) begin
            if (cnt_d == 2'd0) begin
                ent0_d = push_a;
            end else begin
                ent1_d = push_a;
            end
            cnt_d = cnt_d + 2'd1;
        end
        // push_b only happens when the buffer drains to empty, so it lands behind push_a.
        if (push_b_en) begin
            ent1_d = push_b;
            cnt_d  = cnt_d + 2'd1;
        end
    end

    always_comb begin
        swap_cnt_d = swap_cnt_q;
        runt_cnt_d = runt_cnt_q;
        if (m_fire && ent0_q.inc_swap) begin
            swap_cnt_d = swap_cnt_q + 32'd1;
        end
        if (m_fire && ent0_q.inc_runt && (runt_cnt_q != 16'hFFFF)) begin
            runt_cnt_d = runt_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q     <= '0;
            swap_q     <= 1'b0;
            ent0_q     <= '0;
            ent1_q     <= '0;
            cnt_q      <= 2'd0;
            swap_cnt_q <= 32'd0;
            runt_cnt_q <= 16'd0;
        end else begin
            hold_q     <= hold_d;
            swap_q     <= swap_d;
            ent0_q     <= ent0_d;
            ent1_q     <= ent1_d;
            cnt_q      <= cnt_d;
            swap_cnt_q <= swap_cnt_d;
            runt_cnt_q <= runt_cnt_d;
        end
    end

endmodule
